// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Main control FSM of the multi-cycle CPU31 core. It steps each instruction
// through IF -> ID -> EX -> (MEM) -> (WB) on the shared datapath. It drives
// every datapath write enable and mux select. It also bounds memory
// wait-states with a timeout and flags illegal class encodings.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   run                 : allows new instruction fetches
//   imem_req/imem_ready : instruction fetch handshake
//   ir_we               : IR load strobe
//   cls_*               : OR-reduced decoder class flags (sampled in ID)
//   br_cond             : branch compare result (sampled in EX)
//   dmem_req/dmem_we/dmem_ready : data memory handshake
//   rf_we, wb_sel       : register-file write enable / writeback source
//   pc_we, pc_sel       : PC write enable / next-PC source
//   state               : current FSM state encoding
//   illegal, mem_err    : one-cycle error pulses
//   retired             : retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   input  logic             cls_alu_r,
   input  logic             cls_alu_i,
   input  logic             cls_ld,
   input  logic             cls_st,
   input  logic             cls_br,
   input  logic             cls_j,
   input  logic             cls_jal,
   input  logic             cls_jr,
   input  logic             br_cond,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             mem_err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   // Class vector bit positions
   localparam int C_ALU_R = 0;
   localparam int C_ALU_I = 1;
   localparam int C_LD    = 2;
   localparam int C_ST    = 3;
   localparam int C_BR    = 4;
   localparam int C_J     = 5;
   localparam int C_JAL   = 6;
   localparam int C_JR    = 7;

   // Wait-count value of the last cycle a request may still be answered
   localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic [7:0]       r_cls;
   logic [CNT_W-1:0] r_retired;

   state_t           w_next_state;
   logic             w_retire;
   logic             w_cnt_inc;
   logic [7:0]       w_cls;
   logic             w_cls_onehot;
   logic             w_wait_last;

   assign w_cls = {cls_jr, cls_jal, cls_j, cls_br, cls_st, cls_ld, cls_alu_i, cls_alu_r};
   assign w_cls_onehot = (w_cls != 8'd0) && ((w_cls & (w_cls - 8'd1)) == 8'd0);
   assign w_wait_last  = (r_wait_cnt == LP_WAIT_LAST);

   assign state   = r_state;
   assign retired = r_retired;

   // Next-state, strobe and select decode from state, latched class and handshakes
   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      w_cnt_inc    = 1'b0;
      imem_req     = 1'b0;
      ir_we        = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = 2'b00;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      illegal      = 1'b0;
      mem_err      = 1'b0;
      case (r_state)
         S_IF: begin
            // rst_n gating keeps the fetch request low while reset is held
            if (run && rst_n) begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we        = 1'b1;
                  w_next_state = S_ID;
               end else if (w_wait_last) begin
                  mem_err      = 1'b1;
                  w_next_state = S_HALT;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end else begin
               w_next_state = S_IF;
            end
         end
         S_ID: begin
            if (w_cls_onehot) begin
               w_next_state = S_EX;
            end else begin
               illegal      = 1'b1;
               pc_we        = 1'b1;
               w_next_state = S_IF;
            end
         end
         S_EX: begin
            if (r_cls[C_ALU_R] || r_cls[C_ALU_I]) begin
               w_next_state = S_WB;
            end else if (r_cls[C_LD] || r_cls[C_ST]) begin
               w_next_state = S_MEM;
            end else if (r_cls[C_BR]) begin
               pc_we        = 1'b1;
               pc_sel       = br_cond ? 2'b01 : 2'b00;
               w_retire     = 1'b1;
               w_next_state = S_IF;
            end else if (r_cls[C_J]) begin
               pc_we        = 1'b1;
               pc_sel       = 2'b10;
               w_retire     = 1'b1;
               w_next_state = S_IF;
            end else if (r_cls[C_JAL]) begin
               pc_we        = 1'b1;
               pc_sel       = 2'b10;
               rf_we        = 1'b1;
               wb_sel       = 2'b10;
               w_retire     = 1'b1;
               w_next_state = S_IF;
            end else if (r_cls[C_JR]) begin
               pc_we        = 1'b1;
               pc_sel       = 2'b11;
               w_retire     = 1'b1;
               w_next_state = S_IF;
            end else begin
               // Unreachable: ID only enters EX with a one-hot class
               w_next_state = S_IF;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = r_cls[C_ST];
            if (dmem_ready) begin
               if (r_cls[C_ST]) begin
                  pc_we        = 1'b1;
                  w_retire     = 1'b1;
                  w_next_state = S_IF;
               end else begin
                  w_next_state = S_WB;
               end
            end else if (w_wait_last) begin
               mem_err      = 1'b1;
               w_next_state = S_HALT;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WB: begin
            rf_we        = 1'b1;
            wb_sel       = r_cls[C_LD] ? 2'b01 : 2'b00;
            pc_we        = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_IF;
         end
         S_HALT: begin
            w_next_state = S_HALT;
         end
         default: begin
            w_next_state = S_IF;
         end
      endcase
   end

   // State, wait counter, class latch and retire counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IF;
         r_wait_cnt <= 8'd0;
         r_cls      <= 8'd0;
         r_retired  <= '0;
      end else begin
         r_state <= w_next_state;
         // w_cnt_inc is only set while staying put, so any state change clears
         r_wait_cnt <= w_cnt_inc ? (r_wait_cnt + 8'd1) : 8'd0;
         if (r_state == S_ID) begin
            r_cls <= w_cls;
         end else begin
            r_cls <= r_cls;
         end
         if (w_retire) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_retired <= r_retired;
         end
      end
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Table-driven bench for multi_cycle_ctrl. Each record holds one cycle of
// inputs and the outputs expected in that cycle. The expected outputs are
// pushed to a scoreboard queue when the inputs are driven and popped and
// compared once the outputs have settled, half a clock away from the edge.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run, imem_ready, br_cond, dmem_ready;
   logic        cls_alu_r, cls_alu_i, cls_ld, cls_st, cls_br, cls_j, cls_jal, cls_jr;
   logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, illegal, mem_err;
   logic [1:0]  wb_sel, pc_sel;
   logic [2:0]  state;
   logic [31:0] retired;

   // s6 = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we}
   typedef struct packed {
      logic [2:0]  st;
      logic [5:0]  s6;
      logic [1:0]  wb;
      logic [1:0]  pcs;
      logic        ill;
      logic        err;
      logic [31:0] ret;
   } out_t;

   // in4 = {run, imem_ready, br_cond, dmem_ready}
   typedef struct {
      string      name;
      logic [3:0] in4;
      logic [7:0] cls;
      out_t       exp;
   } vec_t;

   vec_t tbl[$];
   out_t sb_q[$];
   out_t act_s;
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [7:0] C_NONE = 8'h00, C_ALUR = 8'h01, C_ALUI = 8'h02, C_LD = 8'h04;
   localparam logic [7:0] C_ST = 8'h08, C_BR = 8'h10, C_J = 8'h20, C_JAL = 8'h40, C_JR = 8'h80;

   multi_cycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_ready(imem_ready),
      .ir_we(ir_we), .cls_alu_r(cls_alu_r), .cls_alu_i(cls_alu_i), .cls_ld(cls_ld),
      .cls_st(cls_st), .cls_br(cls_br), .cls_j(cls_j), .cls_jal(cls_jal), .cls_jr(cls_jr),
      .br_cond(br_cond), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
      .illegal(illegal), .mem_err(mem_err), .retired(retired)
   );

   always #5 clk = ~clk;

   assign act_s = {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
                   wb_sel, pc_sel, illegal, mem_err, retired};

   // Append one cycle record to the vector table
   task automatic tv(input string n, input logic [3:0] in4, input logic [7:0] cls,
                     input logic [2:0] st, input logic [5:0] s6, input logic [1:0] wb,
                     input logic [1:0] pcs, input logic ill, input logic err,
                     input int unsigned ret);
      vec_t v;
      v.name    = n;
      v.in4     = in4;
      v.cls     = cls;
      v.exp.st  = st;
      v.exp.s6  = s6;
      v.exp.wb  = wb;
      v.exp.pcs = pcs;
      v.exp.ill = ill;
      v.exp.err = err;
      v.exp.ret = ret[31:0];
      tbl.push_back(v);
   endtask

   // Pop the oldest scoreboard entry and compare it with the settled outputs
   task automatic check_pop(input string n);
      out_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (act_s !== e) begin
         n_fail++;
         $display("FAIL %s: got st=%0d strb=%b wb=%b pcs=%b ill=%b err=%b ret=%0d, expected st=%0d strb=%b wb=%b pcs=%b ill=%b err=%b ret=%0d",
                  n, act_s.st, act_s.s6, act_s.wb, act_s.pcs, act_s.ill, act_s.err, act_s.ret,
                  e.st, e.s6, e.wb, e.pcs, e.ill, e.err, e.ret);
      end
   endtask

   // Expect the all-zero reset output set right now
   task automatic reset_check(input string n);
      sb_q.push_back('0);
      #1;
      check_pop(n);
   endtask

   // Apply every queued record (starting on a falling edge) and empty the table
   task automatic run_tbl();
      foreach (tbl[k]) begin
         {run, imem_ready, br_cond, dmem_ready} = tbl[k].in4;
         {cls_jr, cls_jal, cls_j, cls_br, cls_st, cls_ld, cls_alu_i, cls_alu_r} = tbl[k].cls;
         sb_q.push_back(tbl[k].exp);
         #1;
         check_pop(tbl[k].name);
         @(posedge clk);
         @(negedge clk);
      end
      tbl.delete();
   endtask

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      {run, imem_ready, br_cond, dmem_ready} = 4'b0000;
      {cls_jr, cls_jal, cls_j, cls_br, cls_st, cls_ld, cls_alu_i, cls_alu_r} = 8'h00;
      #2;
      reset_check("reset_initial");
      @(negedge clk);
      rst_n = 1'b1;

      // Two back-to-back R-type ALU ops: 4 cycles each
      for (int i = 0; i < 2; i++) begin
         tv("alu_r_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, i);
         tv("alu_r_id", 4'b1100, C_ALUR, 3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, i);
         tv("alu_r_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, i);
         tv("alu_r_wb", 4'b1100, C_NONE, 3'd4, 6'b000011, 2'b00, 2'b00, 1'b0, 1'b0, i);
      end
      // Load with three data wait-states: 8 cycles
      tv("lw_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 2);
      tv("lw_id", 4'b1100, C_LD,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 2);
      tv("lw_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 2);
      for (int i = 0; i < 3; i++)
         tv("lw_mem_wait", 4'b1100, C_NONE, 3'd3, 6'b001000, 2'b00, 2'b00, 1'b0, 1'b0, 2);
      tv("lw_mem_rdy", 4'b1101, C_NONE, 3'd3, 6'b001000, 2'b00, 2'b00, 1'b0, 1'b0, 2);
      tv("lw_wb", 4'b1100, C_NONE, 3'd4, 6'b000011, 2'b01, 2'b00, 1'b0, 1'b0, 2);
      // Branch taken / not taken, jal, jr, j: 3 cycles each
      tv("beq_t_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 3);
      tv("beq_t_id", 4'b1100, C_BR,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 3);
      tv("beq_t_ex", 4'b1110, C_NONE, 3'd2, 6'b000001, 2'b00, 2'b01, 1'b0, 1'b0, 3);
      tv("beq_n_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 4);
      tv("beq_n_id", 4'b1100, C_BR,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 4);
      tv("beq_n_ex", 4'b1100, C_NONE, 3'd2, 6'b000001, 2'b00, 2'b00, 1'b0, 1'b0, 4);
      tv("jal_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 5);
      tv("jal_id", 4'b1100, C_JAL,  3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 5);
      tv("jal_ex", 4'b1100, C_NONE, 3'd2, 6'b000011, 2'b10, 2'b10, 1'b0, 1'b0, 5);
      tv("jr_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 6);
      tv("jr_id", 4'b1100, C_JR,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 6);
      tv("jr_ex", 4'b1100, C_NONE, 3'd2, 6'b000001, 2'b00, 2'b11, 1'b0, 1'b0, 6);
      tv("j_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 7);
      tv("j_id", 4'b1100, C_J,    3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 7);
      tv("j_ex", 4'b1100, C_NONE, 3'd2, 6'b000001, 2'b00, 2'b10, 1'b0, 1'b0, 7);
      // I-type ALU op, then zero-wait store (4 cycles)
      tv("alu_i_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 8);
      tv("alu_i_id", 4'b1100, C_ALUI, 3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 8);
      tv("alu_i_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 8);
      tv("alu_i_wb", 4'b1100, C_NONE, 3'd4, 6'b000011, 2'b00, 2'b00, 1'b0, 1'b0, 8);
      tv("sw_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 9);
      tv("sw_id", 4'b1100, C_ST,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 9);
      tv("sw_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 9);
      tv("sw_mem", 4'b1101, C_NONE, 3'd3, 6'b001101, 2'b00, 2'b00, 1'b0, 1'b0, 9);
      // Illegal encodings: no flag, then two flags
      tv("ill0_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      tv("ill0_id", 4'b1100, C_NONE, 3'd1, 6'b000001, 2'b00, 2'b00, 1'b1, 1'b0, 10);
      tv("ill2_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      tv("ill2_id", 4'b1100, C_LD | C_ST, 3'd1, 6'b000001, 2'b00, 2'b00, 1'b1, 1'b0, 10);
      run_tbl();

      // run low for 40 cycles, then fetch answered in the 16th request cycle
      for (int i = 0; i < 40; i++)
         tv("idle", 4'b0000, C_NONE, 3'd0, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      for (int i = 0; i < 15; i++)
         tv("fetch_wait", 4'b1000, C_NONE, 3'd0, 6'b100000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      tv("fetch_last", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      tv("late_id", 4'b1100, C_ALUR, 3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      tv("late_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      tv("late_wb", 4'b1100, C_NONE, 3'd4, 6'b000011, 2'b00, 2'b00, 1'b0, 1'b0, 10);
      // Store never answered: 16 MEM cycles, mem_err in the last, then HALT
      tv("swto_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 11);
      tv("swto_id", 4'b1100, C_ST,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 11);
      tv("swto_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 11);
      for (int i = 0; i < 15; i++)
         tv("swto_wait", 4'b1100, C_NONE, 3'd3, 6'b001100, 2'b00, 2'b00, 1'b0, 1'b0, 11);
      tv("swto_err", 4'b1100, C_NONE, 3'd3, 6'b001100, 2'b00, 2'b00, 1'b0, 1'b1, 11);
      for (int i = 0; i < 3; i++)
         tv("halt", 4'b1100, C_NONE, 3'd5, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 11);
      run_tbl();
      rst_n = 1'b0;
      reset_check("reset_from_halt");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Fetch never answered: mem_err in the 16th IF cycle, then HALT
      for (int i = 0; i < 15; i++)
         tv("ifto_wait", 4'b1000, C_NONE, 3'd0, 6'b100000, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      tv("ifto_err", 4'b1000, C_NONE, 3'd0, 6'b100000, 2'b00, 2'b00, 1'b0, 1'b1, 0);
      for (int i = 0; i < 2; i++)
         tv("ifto_halt", 4'b1100, C_NONE, 3'd5, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      run_tbl();
      rst_n = 1'b0;
      reset_check("reset_after_ifto");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while a load waits in MEM drops dmem_req at once
      tv("lwr_if", 4'b1100, C_NONE, 3'd0, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      tv("lwr_id", 4'b1100, C_LD,   3'd1, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      tv("lwr_ex", 4'b1100, C_NONE, 3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      for (int i = 0; i < 2; i++)
         tv("lwr_mem", 4'b1100, C_NONE, 3'd3, 6'b001000, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      run_tbl();
      rst_n = 1'b0;
      reset_check("reset_mid_mem");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the CPU31 core. It sequences instruction fetch, decode, execute, data-memory access and writeback over the shared datapath: PC, IR, register file, ALU and a single memory port. It consumes instruction-class flags produced by OR-reducing the per-instruction decoder flags. It drives all datapath write enables and mux selects, and handles memory wait-states, memory timeouts and illegal encodings.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request waits for ready before error; legal range 1..255
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  allows new fetches when high
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
ir_we  out  1  IR load strobe
cls_alu_r  in  1  R-type ALU/shift op (add..srav); valid in ID only
cls_alu_i  in  1  I-type ALU op (addi..sltiu, lui); valid in ID only
cls_ld  in  1  lw; valid in ID only
cls_st  in  1  sw; valid in ID only
cls_br  in  1  beq/bne; valid in ID only
cls_j  in  1  j; valid in ID only
cls_jal  in  1  jal; valid in ID only
cls_jr  in  1  jr; valid in ID only
br_cond  in  1  branch condition from ALU compare, valid in EX
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ready  in  1  data access completes this cycle
rf_we  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
pc_we  out  1  PC write enable
pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
state  out  3  current state encoding
illegal  out  1  one-cycle pulse: bad class encoding
mem_err  out  1  one-cycle pulse: memory timeout
retired  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Registered state; outputs decode combinationally from state, latched class and handshake inputs.
- Reset (async, rst_n low):
  - state=IF, wait counter=0, latched class=0, retired=0.
  - Every output is 0 and both selects are 00, except state=0.
  - Reset asserted mid-MEM drops dmem_req immediately.
- Default values: any strobe not listed for a state is 0; wb_sel and pc_sel are 00.
- Wait counter:
  - Increments each cycle in IF (with run=1) or MEM while ready is low.
  - Clears on every state change.
  - Held at 0 in IF while run=0.
- IF:
  - imem_req=run. run=0: stay in IF, no request.
  - imem_ready=1 (with run=1): ir_we=1 that cycle, next ID.
  - Timeout: wait_cnt==MEM_TIMEOUT-1 and imem_ready=0 gives mem_err=1 that cycle, next HALT. Ready arriving in the final cycle is accepted.
- ID (1 cycle):
  - Latch the 8 class flags.
  - Exactly one flag set: next EX.
  - Zero or more than one flag set: illegal=1, pc_we=1 with pc_sel=00, retired unchanged, next IF.
- EX (1 cycle):
  - alu_r/alu_i: next WB.
  - ld/st: next MEM.
  - br: pc_we=1, pc_sel = br_cond ? 01 : 00, retire, next IF.
  - j: pc_we=1, pc_sel=10, retire, next IF.
  - jal: pc_we=1, pc_sel=10, rf_we=1, wb_sel=10, retire, next IF.
  - jr: pc_we=1, pc_sel=11, retire, next IF.
- MEM:
  - dmem_req=1; dmem_we=1 for st only, held stable until ready.
  - dmem_ready=1 with ld: next WB.
  - dmem_ready=1 with st: pc_we=1 with pc_sel=00, retire, next IF.
  - Timeout: same rule as IF; mem_err=1, next HALT.
- WB (1 cycle): rf_we=1, wb_sel = ld ? 01 : 00, pc_we=1 with pc_sel=00, retire, next IF.
- HALT: all strobes 0. Exits only via rst_n.
- Retire: retired increments by 1 on the clock edge ending the retiring cycle. Illegal and timed-out instructions never retire.
- Instruction latency with zero wait-states:
  - ALU op: 4 cycles.
  - Branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
1. rst_n release, run=1, imem_ready=1 every cycle, cls_alu_r → state sequence 0,1,2,4,0; WB has rf_we=1, wb_sel=00, pc_we=1; retired=1 after 4 cycles, 2 after 8.
2. lw, dmem_ready low 3 cycles then high → MEM lasts 4 cycles with dmem_req=1, dmem_we=0; then WB with wb_sel=01; instruction takes 8 cycles; retired+1.
3. beq with br_cond=1 → EX has pc_we=1, pc_sel=01; repeat with br_cond=0 → pc_sel=00; each takes 3 cycles, retired+1 each. jal → EX has rf_we=1, wb_sel=10, pc_sel=10. jr → pc_sel=11.
4. ID flags all 0, then cls_ld and cls_st both 1 → illegal=1 for exactly one cycle each, pc_we=1 with pc_sel=00, next state IF, retired unchanged.
5. sw with dmem_ready never high → dmem_req/dmem_we high for 16 MEM cycles, mem_err pulses in the 16th, state=5 thereafter. Then assert rst_n low → state=0 and retired=0 immediately, without waiting for a clock edge.
6. run=0 in IF for 40 cycles → imem_req=0, no mem_err. Then run=1 with imem_ready on cycle 16 of the request → accepted, ir_we pulse, next ID.
